// File: rtl/sb_fp_pkg.sv
// rtl/sb_fp_pkg.sv - shared single-precision float constants and types
//
// Used by the sequential divider and the sequential multiplier.
// Field widths, bias, canonical quiet NaN, infinity magnitude, operand
// class encoding and the divider state encoding.

package sb_fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] INF_MAG = 32'h7F80_0000;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_DIVIDE,
    ST_NORM,
    ST_DONE
  } div_state_e;

endpackage

// File: rtl/sb_fp_classify.sv
// rtl/sb_fp_classify.sv - combinational float operand classifier
//
// Ports:
//   op_i   : IEEE-754 operand
//   cls_o  : ZERO (exponent 0, subnormals flushed), INF, NAN or NORM
//   sign_o : sign bit
//   exp_o  : biased exponent field
//   man_o  : mantissa with the hidden 1 prepended (meaningful for NORM only)

module sb_fp_classify
  import sb_fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output fp_class_e            cls_o,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W:0]       man_o
);

  logic [MAN_W-1:0] frac;

  assign sign_o = op_i[EXP_W+MAN_W];
  assign exp_o  = op_i[EXP_W+MAN_W-1:MAN_W];
  assign frac   = op_i[MAN_W-1:0];
  assign man_o  = {1'b1, frac};

  always_comb begin
    cls_o = CLS_NORM;
    if (exp_o == '0) begin
      cls_o = CLS_ZERO;
    end else if (exp_o == '1) begin
      cls_o = (frac == '0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/sb_divider.sv
// rtl/sb_divider.sv - sequential single-precision float divider (a / b)
//
// Restoring mantissa division, one quotient bit per clock, truncation.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : request, sampled only in IDLE
//   a, b        : dividend and divisor
//   busy        : high from the cycle after acceptance until done
//   done        : one-cycle pulse, result and flags valid
//   result      : quotient, held until the next accepted start
//   overflow, underflow, div_by_zero, invalid : mutually exclusive flags

module sb_divider
  import sb_fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int BIAS  = FP_BIAS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 div_by_zero,
  output logic                 invalid
);

  localparam int FP_W    = 1 + EXP_W + MAN_W;
  localparam int Q_W     = MAN_W + 2;          // quotient bits, one per DIVIDE cycle
  localparam int REM_W   = MAN_W + 3;          // remainder stays below 2*divisor
  localparam int SE_W    = EXP_W + 2;          // exponent with sign and headroom
  localparam int CNT_W   = $clog2(Q_W);
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  div_state_e         state_q, state_d;
  logic [FP_W-1:0]    a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic [SE_W-1:0]    exp_q, exp_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [MAN_W:0]     div_q, div_d;
  logic [Q_W-1:0]     quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FP_W-1:0]    result_q, result_d;
  logic               ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d, inv_q, inv_d;

  fp_class_e          cls_a, cls_b;
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W:0]     ma, mb;

  logic [REM_W-1:0]   rem_diff;
  logic               rem_ge;
  logic [SE_W-1:0]    exp_n;
  logic [MAN_W-1:0]   man_n;
  logic [FP_W-1:0]    inf_s, zero_s;

  sb_fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .op_i(a_q), .cls_o(cls_a), .sign_o(sa), .exp_o(ea), .man_o(ma)
  );

  sb_fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .op_i(b_q), .cls_o(cls_b), .sign_o(sb), .exp_o(eb), .man_o(mb)
  );

  assign rem_diff = rem_q - {2'b00, div_q};
  assign rem_ge   = rem_q >= {2'b00, div_q};

  // A leading zero quotient bit means the mantissa ratio was below 1.
  assign exp_n = quo_q[Q_W-1] ? exp_q : exp_q - SE_W'(1);
  assign man_n = quo_q[Q_W-1] ? quo_q[MAN_W:1] : quo_q[MAN_W-1:0];

  assign inf_s  = {sa ^ sb, INF_MAG[FP_W-2:0]};
  assign zero_s = {sa ^ sb, {(FP_W-1){1'b0}}};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dbz_d    = dbz_q;
    inv_d    = inv_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          result_d = '0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          dbz_d    = 1'b0;
          inv_d    = 1'b0;
          state_d  = ST_UNPACK;
        end
      end

      ST_UNPACK: begin
        sign_d  = sa ^ sb;
        state_d = ST_DONE;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
            (cls_a == CLS_INF  && cls_b == CLS_INF)) begin
          result_d = QNAN[FP_W-1:0];
          inv_d    = 1'b1;
        end else if (cls_b == CLS_ZERO && cls_a == CLS_NORM) begin
          result_d = inf_s;
          dbz_d    = 1'b1;
        end else if (cls_a == CLS_ZERO || cls_b == CLS_INF) begin
          result_d = zero_s;
        end else if (cls_a == CLS_INF) begin
          result_d = inf_s;
        end else begin
          exp_d   = SE_W'(ea) - SE_W'(eb) + SE_W'(BIAS);
          rem_d   = {2'b00, ma};
          div_d   = mb;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = ST_DIVIDE;
        end
      end

      ST_DIVIDE: begin
        rem_d = (rem_ge ? rem_diff : rem_q) << 1;
        quo_d = {quo_q[Q_W-2:0], rem_ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(Q_W - 1)) begin
          state_d = ST_NORM;
        end
      end

      ST_NORM: begin
        state_d = ST_DONE;
        // exp_n MSB set means the biased exponent went negative.
        if (!exp_n[SE_W-1] && exp_n >= SE_W'(EXP_MAX)) begin
          result_d = {sign_q, INF_MAG[FP_W-2:0]};
          ovf_d    = 1'b1;
        end else if (exp_n[SE_W-1] || exp_n == '0) begin
          result_d = {sign_q, {(FP_W-1){1'b0}}};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_n[EXP_W-1:0], man_n};
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dbz_q    <= dbz_d;
      inv_q    <= inv_d;
    end
  end

  assign busy        = (state_q == ST_UNPACK) || (state_q == ST_DIVIDE) || (state_q == ST_NORM);
  assign done        = (state_q == ST_DONE);
  assign result      = result_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;
  assign invalid     = inv_q;

endmodule

// File: tb/tb_sb_divider.sv
// tb/tb_sb_divider.sv - scoreboard bench for sb_divider

module tb_sb_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;
  logic        invalid;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // flags order: {overflow, underflow, div_by_zero, invalid}
  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  sb_divider dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a_in),
    .b(b_in),
    .busy(busy),
    .done(done),
    .result(result),
    .overflow(overflow),
    .underflow(underflow),
    .div_by_zero(div_by_zero),
    .invalid(invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got result %h with no pending request", result);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "_result"}, result, mon_e.res);
        check({mon_e.name, "_flags"}, {28'b0, overflow, underflow, div_by_zero, invalid},
              {28'b0, mon_e.flg});
        check({mon_e.name, "_latency"}, 32'(cyc - mon_e.t0 + 1), 32'(mon_e.lat));
        check({mon_e.name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] res, input logic [3:0] flg,
                       input int lat, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    a_in  = av;
    b_in  = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    e.res  = res;
    e.flg  = flg;
    e.lat  = lat;
    e.t0   = cyc;
    e.name = name;
    sb_q.push_back(e);
    check({name, "_busy_after_start"}, {31'b0, busy}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, {31'b0, busy}, 32'd0);
    check({name, "_done"}, {31'b0, done}, 32'd0);
    check({name, "_result"}, result, 32'd0);
    check({name, "_flags"}, {28'b0, overflow, underflow, div_by_zero, invalid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 28, "six_by_two");
    drain();
    issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 4'b0000, 28, "one_by_three");
    drain();
    issue(32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 4'b0000, 28, "neg_7p5_by_2p5");
    drain();
    issue(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, 28, "one_by_one");
    drain();
    issue(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 4'b0010, 2, "neg_one_by_zero");
    drain();
    issue(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0001, 2, "zero_by_zero");
    drain();
    issue(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b0001, 2, "inf_by_inf");
    drain();
    issue(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b0001, 2, "nan_by_one");
    drain();
    issue(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0000, 2, "negzero_by_two");
    drain();
    issue(32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 4'b0000, 2, "two_by_neginf");
    drain();
    issue(32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0000, 2, "inf_by_zero");
    drain();
    issue(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000, 2, "subnormal_flush");
    drain();
    issue(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 4'b1000, 28, "overflow");
    drain();
    issue(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 4'b0100, 28, "underflow");
    drain();

    // A start pulse while busy must not disturb the operation in flight.
    issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 28, "start_ignored");
    repeat (8) @(posedge clk);
    #1;
    a_in  = 32'h3F80_0000;
    b_in  = 32'h4040_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_ignored_busy", {31'b0, busy}, 32'd1);
    drain();

    // Reset in the middle of DIVIDE aborts without a done pulse.
    @(posedge clk);
    #1;
    a_in  = 32'h40C0_0000;
    b_in  = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("abort_busy_before_reset", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done_busy", {31'b0, busy}, 32'd0);

    issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 4'b0000, 28, "after_abort");
    drain();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sb_divider.md
Name: sb_divider

Overview:
- Sequential IEEE-754 single-precision floating-point divider (a / b).
- Companion to the calculator's sequential float multiplier; together they form the multiply/divide pair of the arithmetic unit.
- Replaces external step-count sequencing with a start/busy/done handshake.
- Restoring mantissa division, one quotient bit per clock, truncation rounding. Subnormals are flushed to zero.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa width (hidden bit excluded)
- BIAS, 127, exponent bias

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  32  dividend, IEEE-754 single
- b  in  32  divisor, IEEE-754 single
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse when result and flags are valid
- result  out  32  quotient; held until the next accepted start
- overflow  out  1  finite result exponent >= 255
- underflow  out  1  finite nonzero result exponent <= 0
- div_by_zero  out  1  finite nonzero a divided by zero
- invalid  out  1  NaN operand, 0/0, or inf/inf

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, result, all flags = 0; internal regs cleared.
- Reset mid-operation aborts the operation with no done pulse.
- One clock domain (clk); asynchronous active-low reset rst_n.
- IDLE
  - On start=1, latch a and b, clear flags, go to UNPACK.
  - start while busy is ignored; the latched operands are unaffected.
- UNPACK (1 cycle): classify operands. Exponent 0 is zero (flush). Exponent 255 is inf if mantissa==0, else NaN.
  - Special cases, checked in this priority order, go directly to DONE:
    - NaN operand, 0/0, or inf/inf -> 0x7FC00000, invalid=1.
    - b zero with a finite nonzero -> {sign, 0x7F800000 magnitude}, div_by_zero=1.
    - a zero or b inf -> signed zero.
    - a inf -> signed inf.
  - Otherwise:
    - sign = a[31]^b[31].
    - exp = ea - eb + BIAS, computed in 10-bit signed.
    - Load the remainder with {1,ma} and the divisor with {1,mb}.
    - Go to DIVIDE with a step counter of 0.
- DIVIDE (exactly 25 cycles, counter 0..24)
  - Each cycle: trial = rem - div. If non-negative, rem = trial << 1 and q bit = 1; else rem = rem << 1 and q bit = 0.
  - Quotient bits shift into q[24:0], MSB first.
  - After count 24, go to NORM.
- NORM (1 cycle)
  - If q[24]=1: mantissa = q[23:1].
  - Else: mantissa = q[22:0] and exp = exp - 1.
  - If exp >= 255: result = signed inf, overflow=1.
  - If exp <= 0: result = signed zero, underflow=1.
  - Otherwise pack {sign, exp[7:0], mantissa}.
- DONE (1 cycle): done=1, busy=0; return to IDLE. A start in the DONE cycle is ignored.
- Latency from the start-sampling edge to the done pulse:
  - Normal operands: 28 cycles (UNPACK 1 + DIVIDE 25 + NORM 1 + DONE 1).
  - Special cases: 2 cycles.
- Rounding is truncation only; no sticky bit is kept.
- Flags are mutually exclusive, and valid/stable from the done cycle until the next accepted start.

Decomposition:
- Shared package sb_fp_pkg:
  - field width/bias constants
  - QNAN (0x7FC00000) and INF_MAG (0x7F800000)
  - class encoding typedef: ZERO / NORM / INF / NAN
  - divider state enum
- The multiplier will also adopt sb_fp_pkg.
- One natural sub-module: sb_fp_classify. It is combinational: 32-bit operand -> class, sign, exponent, mantissa with hidden bit. Instantiated twice (a and b).

Test Plan:
- a=0x40C00000 (6.0), b=0x40000000 (2.0), start pulse -> done exactly 28 cycles later, result=0x40400000, all flags 0.
- a=0x3F800000 (1.0), b=0x40400000 (3.0) -> result=0x3EAAAAAA (truncated; exercises the q[24]=0 normalize path), flags 0.
- a=0xBF800000, b=0x00000000 -> done at cycle 2, result=0xFF800000, div_by_zero=1. Then a=0,b=0 -> 0x7FC00000, invalid=1. Then a=0x7F800000,b=0x7F800000 -> 0x7FC00000, invalid=1.
- a=0x7F000000, b=0x00800000 -> result=0x7F800000, overflow=1. a=0x00800000, b=0x7F000000 -> result=0x00000000, underflow=1.
- Start 6.0/2.0, re-pulse start with other operands at cycle 10 -> ignored, result still 0x40400000 at cycle 28. Second run: drop rst_n at cycle 15 -> outputs 0 immediately, no done. Then a new start completes normally.
